// File: rtl/host_mem_responder.sv
// Host-side cache-line responder: fixed-latency reads/writes against a DEPTH-line store.
// Ready pulses RD_LAT+1 / WR_LAT+1 edges after accept; one transaction at a time, gos while busy are dropped and flagged.
module host_mem_responder #(
  parameter int                CL_WIDTH  = 512,
  parameter int                ADDR_W    = 64,
  parameter int                DEPTH     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RD_LAT    = 4,
  parameter int                WR_LAT    = 2,
  localparam int               IDX_W     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_re,
  input  logic                host_rgo,
  input  logic                host_we,
  input  logic                host_wgo,
  input  logic [ADDR_W-1:0]   corrected_address,
  input  logic [CL_WIDTH-1:0] host_data_bus_write_out,
  output logic                host_rd_ready,
  output logic                host_wr_ready,
  output logic [CL_WIDTH-1:0] host_data_bus_read_in,
  output logic                busy,
  output logic                err_oob,
  output logic                err_ovl,
  output logic [15:0]         rd_count,
  output logic [15:0]         wr_count,
  input  logic                bd_we,
  input  logic [IDX_W-1:0]    bd_idx,
  input  logic [CL_WIDTH-1:0] bd_data
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    lat_idx;
  logic                lat_oob;
  logic [CL_WIDTH-1:0] lat_data;
  logic [CL_WIDTH-1:0] store [DEPTH];

  logic              rd_go, wr_go;
  logic [ADDR_W-1:0] off_line;
  logic              in_range;

  assign rd_go    = host_rgo & host_re;
  assign wr_go    = host_wgo & host_we;
  // Line offset from the base; the low 6 byte-offset bits fall away in the shift.
  assign off_line = (corrected_address - BASE_ADDR) >> 6;
  assign in_range = (corrected_address >= BASE_ADDR) && (off_line < ADDR_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (state == IDLE && bd_we)
      store[bd_idx] <= bd_data;
    else if (state == WR_RESP && !lat_oob)
      store[lat_idx] <= lat_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      lat_idx               <= '0;
      lat_oob               <= 1'b0;
      lat_data              <= '0;
      host_rd_ready         <= 1'b0;
      host_wr_ready         <= 1'b0;
      host_data_bus_read_in <= '0;
      busy                  <= 1'b0;
      err_oob               <= 1'b0;
      err_ovl               <= 1'b0;
      rd_count              <= '0;
      wr_count              <= '0;
    end else begin
      host_rd_ready         <= 1'b0;
      host_wr_ready         <= 1'b0;
      host_data_bus_read_in <= '0;
      if ((state != IDLE && (rd_go || wr_go)) || (rd_go && wr_go))
        err_ovl <= 1'b1;

      case (state)
        IDLE: begin
          if (rd_go || wr_go) begin
            lat_idx <= off_line[IDX_W-1:0];
            lat_oob <= !in_range;
            busy    <= 1'b1;
            if (!in_range)
              err_oob <= 1'b1;
          end
          // A simultaneous write is dropped in favour of the read.
          if (rd_go) begin
            state <= RD_WAIT;
            cnt   <= CNT_W'(RD_LAT - 1);
          end else if (wr_go) begin
            state    <= WR_WAIT;
            cnt      <= CNT_W'(WR_LAT - 1);
            lat_data <= host_data_bus_write_out;
          end
        end
        RD_WAIT: begin
          if (cnt == '0) state <= RD_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RD_RESP: begin
          host_rd_ready         <= 1'b1;
          host_data_bus_read_in <= lat_oob ? '0 : store[lat_idx];
          rd_count              <= rd_count + 16'd1;
          busy                  <= 1'b0;
          state                 <= IDLE;
        end
        WR_WAIT: begin
          if (cnt == '0) state <= WR_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        WR_RESP: begin
          host_wr_ready <= 1'b1;
          wr_count      <= wr_count + 16'd1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_mem_responder.sv
// Directed bench for host_mem_responder with a queued scoreboard for ready pulses.
module tb_host_mem_responder;
  localparam int CL_WIDTH = 512;
  localparam int ADDR_W   = 64;
  localparam int DEPTH    = 64;
  localparam int IDX_W    = 6;
  localparam int RD_LAT   = 4;
  localparam int WR_LAT   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                host_re = 1'b0, host_rgo = 1'b0, host_we = 1'b0, host_wgo = 1'b0;
  logic [ADDR_W-1:0]   corrected_address = '0;
  logic [CL_WIDTH-1:0] host_data_bus_write_out = '0;
  logic                host_rd_ready, host_wr_ready, busy, err_oob, err_ovl;
  logic [CL_WIDTH-1:0] host_data_bus_read_in;
  logic [15:0]         rd_count, wr_count;
  logic                bd_we = 1'b0;
  logic [IDX_W-1:0]    bd_idx = '0;
  logic [CL_WIDTH-1:0] bd_data = '0;

  host_mem_responder #(
    .CL_WIDTH(CL_WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .BASE_ADDR('0), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .host_re(host_re), .host_rgo(host_rgo), .host_we(host_we), .host_wgo(host_wgo),
    .corrected_address(corrected_address),
    .host_data_bus_write_out(host_data_bus_write_out),
    .host_rd_ready(host_rd_ready), .host_wr_ready(host_wr_ready),
    .host_data_bus_read_in(host_data_bus_read_in),
    .busy(busy), .err_oob(err_oob), .err_ovl(err_ovl),
    .rd_count(rd_count), .wr_count(wr_count),
    .bd_we(bd_we), .bd_idx(bd_idx), .bd_data(bd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CL_WIDTH-1:0] data;
    int                  edge_no;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      wr_q[$];
  int      cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  bit      prev_rd = 1'b0;

  localparam logic [CL_WIDTH-1:0] P_BEEF = {16{32'hDEADBEEF}};
  localparam logic [CL_WIDTH-1:0] P_A5   = {16{32'hA5A5A5A5}};
  localparam logic [CL_WIDTH-1:0] P_C0   = {16{32'h0C0C0C0C}};
  localparam logic [CL_WIDTH-1:0] P_05   = {16{32'h05050505}};
  localparam logic [CL_WIDTH-1:0] P_06   = {16{32'h06060606}};
  localparam logic [CL_WIDTH-1:0] P_77   = {16{32'h77777777}};
  localparam logic [CL_WIDTH-1:0] P_OLD  = {16{32'h12345678}};
  localparam logic [CL_WIDTH-1:0] P_NEW  = {16{32'h87654321}};
  localparam logic [CL_WIDTH-1:0] P_FF   = {16{32'hFFFF0000}};
  localparam logic [CL_WIDTH-1:0] P_ZERO = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [CL_WIDTH-1:0] act,
                     input logic [CL_WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the head of its queue, on the expected edge.
  always @(negedge clk) begin
    rd_exp_t e;
    if (prev_rd)
      chk("rd_data_cleared", host_data_bus_read_in, P_ZERO);
    prev_rd = host_rd_ready;
    if (host_rd_ready) begin
      chk("rd_ready_expected", CL_WIDTH'(rd_q.size() > 0), CL_WIDTH'(1));
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        chk("rd_data", host_data_bus_read_in, e.data);
        chk("rd_latency_edge", CL_WIDTH'(cyc), CL_WIDTH'(e.edge_no));
      end
    end
    if (host_wr_ready) begin
      chk("wr_ready_expected", CL_WIDTH'(wr_q.size() > 0), CL_WIDTH'(1));
      if (wr_q.size() > 0)
        chk("wr_latency_edge", CL_WIDTH'(cyc), CL_WIDTH'(wr_q.pop_front()));
    end
  end

  task automatic preload(input logic [IDX_W-1:0] idx, input logic [CL_WIDTH-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic issue_read(input logic [ADDR_W-1:0] addr, input logic [CL_WIDTH-1:0] exp);
    rd_exp_t e;
    @(negedge clk);
    host_re = 1'b1; host_rgo = 1'b1; corrected_address = addr;
    @(negedge clk);
    host_re = 1'b0; host_rgo = 1'b0;
    e.data = exp; e.edge_no = cyc + RD_LAT + 1;
    rd_q.push_back(e);
  endtask

  task automatic issue_write(input logic [ADDR_W-1:0] addr, input logic [CL_WIDTH-1:0] d,
                             input bit expect_resp);
    @(negedge clk);
    host_we = 1'b1; host_wgo = 1'b1; corrected_address = addr; host_data_bus_write_out = d;
    @(negedge clk);
    host_we = 1'b0; host_wgo = 1'b0;
    if (expect_resp) wr_q.push_back(cyc + WR_LAT + 1);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
      if (!busy && rd_q.size() == 0 && wr_q.size() == 0) done = 1'b1;
    end
    chk(name, CL_WIDTH'(done), CL_WIDTH'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_ready"}, CL_WIDTH'(host_rd_ready), P_ZERO);
    chk({tag, "_wr_ready"}, CL_WIDTH'(host_wr_ready), P_ZERO);
    chk({tag, "_rd_data"},  host_data_bus_read_in, P_ZERO);
    chk({tag, "_busy"},     CL_WIDTH'(busy), P_ZERO);
    chk({tag, "_err_oob"},  CL_WIDTH'(err_oob), P_ZERO);
    chk({tag, "_err_ovl"},  CL_WIDTH'(err_ovl), P_ZERO);
    chk({tag, "_rd_count"}, CL_WIDTH'(rd_count), P_ZERO);
    chk({tag, "_wr_count"}, CL_WIDTH'(wr_count), P_ZERO);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    preload(6'd0, P_C0);
    preload(6'd3, P_BEEF);
    preload(6'd5, P_05);
    preload(6'd6, P_06);
    preload(6'd7, P_77);
    preload(6'd10, P_OLD);

    // Test 1: preloaded line comes back after RD_LAT+1 edges.
    issue_read(64'hC0, P_BEEF);
    wait_idle("t1_idle");
    chk("t1_rd_count", CL_WIDTH'(rd_count), CL_WIDTH'(1));

    // Test 2: unaligned write, then aligned read-back.
    issue_write(64'h1C4, P_A5, 1'b1);
    wait_idle("t2_wr_idle");
    issue_read(64'h1C0, P_A5);
    wait_idle("t2_rd_idle");
    chk("t2_wr_count", CL_WIDTH'(wr_count), CL_WIDTH'(1));
    chk("t2_err_ovl_clear", CL_WIDTH'(err_ovl), P_ZERO);

    // Test 3: simultaneous rgo/wgo -> read wins, write dropped.
    @(negedge clk);
    host_re = 1'b1; host_rgo = 1'b1; host_we = 1'b1; host_wgo = 1'b1;
    corrected_address = 64'h0; host_data_bus_write_out = P_FF;
    @(negedge clk);
    host_re = 1'b0; host_rgo = 1'b0; host_we = 1'b0; host_wgo = 1'b0;
    rd_q.push_back('{data: P_C0, edge_no: cyc + RD_LAT + 1});
    wait_idle("t3_idle");
    chk("t3_err_ovl", CL_WIDTH'(err_ovl), CL_WIDTH'(1));
    chk("t3_wr_count", CL_WIDTH'(wr_count), CL_WIDTH'(1));
    chk("t3_rd_count", CL_WIDTH'(rd_count), CL_WIDTH'(3));
    issue_read(64'h0, P_C0);
    wait_idle("t3_readback_idle");

    // Test 4: first address past the store.
    chk("t4_err_oob_before", CL_WIDTH'(err_oob), P_ZERO);
    issue_read(64'(DEPTH * 64), P_ZERO);
    wait_idle("t4_rd_idle");
    chk("t4_err_oob", CL_WIDTH'(err_oob), CL_WIDTH'(1));
    issue_write(64'(DEPTH * 64), P_FF, 1'b1);
    wait_idle("t4_wr_idle");
    issue_read(64'h0, P_C0);
    wait_idle("t4_alias_idle");
    chk("t4_wr_count", CL_WIDTH'(wr_count), CL_WIDTH'(2));

    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;

    // Test 5: rgo during RD_WAIT ignored; backdoor outside IDLE ignored; back-to-back reads.
    issue_read(64'hC0, P_BEEF);
    @(negedge clk);
    host_re = 1'b1; host_rgo = 1'b1; corrected_address = 64'h140;
    bd_we = 1'b1; bd_idx = 6'd3; bd_data = P_ZERO;
    @(negedge clk);
    host_re = 1'b0; host_rgo = 1'b0; bd_we = 1'b0;
    #1 chk("t5_err_ovl", CL_WIDTH'(err_ovl), CL_WIDTH'(1));
    chk("t5_busy", CL_WIDTH'(busy), CL_WIDTH'(1));
    repeat (2) @(negedge clk);
    issue_read(64'h140, P_05);
    repeat (RD_LAT) @(negedge clk);
    issue_read(64'h180, P_06);
    wait_idle("t5_idle");
    issue_read(64'hC0, P_BEEF);
    wait_idle("t5_bd_ignored_idle");
    chk("t5_rd_count", CL_WIDTH'(rd_count), CL_WIDTH'(4));

    // Test 6: reset during WR_WAIT loses the write and suppresses wr_ready.
    issue_write(64'h280, P_NEW, 1'b0);
    chk("t6_busy_before_rst", CL_WIDTH'(busy), CL_WIDTH'(1));
    rst = 1'b1;
    #1 check_reset_outputs("t6_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue_read(64'h280, P_OLD);
    wait_idle("t6_idle");
    chk("t6_wr_count", CL_WIDTH'(wr_count), P_ZERO);
    chk("t6_rd_count", CL_WIDTH'(rd_count), CL_WIDTH'(1));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
